// File: rtl/phase_search_ctl.sv
// Phase-search sequencer for the I/Q magnitude demodulator: coarse NCO phase sweep, pick the best
// averaged magnitude, park and report lock/fail. Define PHASE_TRACK_EN for early/late tracking in LOCK.
module phase_search_ctl #(
    parameter int          PHASE_STEP = 16'h1000,
    parameter int          SETTLE_CNT = 1,
    parameter int          ACC_LOG2   = 2,
    parameter logic [7:0]  LOCK_THR   = 8'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [7:0]  demod_value_i,
    input  logic        demod_rdy_i,
    output logic [15:0] phase_o,
    output logic        demod_rst_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        locked_o,
    output logic        fail_o,
    output logic [15:0] best_phase_o,
    output logic [7:0]  best_avg_o
);
    localparam int          AW       = 8 + ACC_LOG2;
    localparam int          NSTEPS   = 65536 / PHASE_STEP;
    localparam logic [16:0] STEP_LST = 17'(NSTEPS - 1);
    localparam logic [4:0]  SMP_LST  = 5'((1 << ACC_LOG2) - 1);
    localparam logic [15:0] PSTEP    = 16'(PHASE_STEP);
    localparam logic [15:0] QSTEP    = PSTEP >> 2;

    typedef enum logic [2:0] {
        IDLE, APPLY, SETTLE, MEASURE, COMPARE, STEP, FINISH, LOCK
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   phase_q, phase_d, best_phase_q, best_phase_d;
    logic [7:0]    best_avg_q, best_avg_d;
    logic          busy_q, busy_d, locked_q, locked_d, fail_q, fail_d;
    logic [16:0]   step_q, step_d;
    logic [3:0]    settle_q, settle_d;
    logic [4:0]    smp_q, smp_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [7:0]    avg;
`ifdef PHASE_TRACK_EN
    logic          trk_q, trk_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    e_avg_q, e_avg_d, l_avg_q, l_avg_d;
    logic [7:0]    w_avg;
    logic [15:0]   w_phase;
`endif

    assign avg = acc_q[ACC_LOG2+7:ACC_LOG2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            best_phase_q <= '0;
            best_avg_q   <= '0;
            busy_q       <= 1'b0;
            locked_q     <= 1'b0;
            fail_q       <= 1'b0;
            step_q       <= '0;
            settle_q     <= '0;
            smp_q        <= '0;
            acc_q        <= '0;
`ifdef PHASE_TRACK_EN
            trk_q        <= 1'b0;
            idx_q        <= '0;
            e_avg_q      <= '0;
            l_avg_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            best_phase_q <= best_phase_d;
            best_avg_q   <= best_avg_d;
            busy_q       <= busy_d;
            locked_q     <= locked_d;
            fail_q       <= fail_d;
            step_q       <= step_d;
            settle_q     <= settle_d;
            smp_q        <= smp_d;
            acc_q        <= acc_d;
`ifdef PHASE_TRACK_EN
            trk_q        <= trk_d;
            idx_q        <= idx_d;
            e_avg_q      <= e_avg_d;
            l_avg_q      <= l_avg_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        best_phase_d = best_phase_q;
        best_avg_d   = best_avg_q;
        busy_d       = busy_q;
        locked_d     = locked_q;
        fail_d       = fail_q;
        step_d       = step_q;
        settle_d     = settle_q;
        smp_d        = smp_q;
        acc_d        = acc_q;
`ifdef PHASE_TRACK_EN
        trk_d        = trk_q;
        idx_d        = idx_q;
        e_avg_d      = e_avg_q;
        l_avg_d      = l_avg_q;
        w_avg        = avg;
        w_phase      = best_phase_q;
`endif
        case (state_q)
            APPLY: begin
                settle_d = 4'(SETTLE_CNT);
                state_d  = SETTLE;
            end
            SETTLE: begin
                // Exit on the strobe that takes the count to zero so no sample is lost.
                if (settle_q == 4'd0 || (demod_rdy_i && settle_q == 4'd1)) begin
                    acc_d   = '0;
                    smp_d   = '0;
                    state_d = MEASURE;
                end else if (demod_rdy_i) begin
                    settle_d = settle_q - 4'd1;
                end
            end
            MEASURE: begin
                if (demod_rdy_i) begin
                    acc_d = acc_q + AW'(demod_value_i);
                    smp_d = smp_q + 5'd1;
                    if (smp_q == SMP_LST) state_d = COMPARE;
                end
            end
            COMPARE: begin
`ifdef PHASE_TRACK_EN
                if (trk_q) begin
                    if (idx_q == 2'd0) begin
                        e_avg_d = avg;
                        idx_d   = 2'd1;
                        phase_d = best_phase_q + QSTEP;
                        state_d = APPLY;
                    end else if (idx_q == 2'd1) begin
                        l_avg_d = avg;
                        idx_d   = 2'd2;
                        phase_d = best_phase_q;
                        state_d = APPLY;
                    end else begin
                        // Strict wins only; any tie leaves the centre in place.
                        if (e_avg_q > l_avg_q && e_avg_q > avg) begin
                            w_avg   = e_avg_q;
                            w_phase = best_phase_q - QSTEP;
                        end else if (l_avg_q > e_avg_q && l_avg_q > avg) begin
                            w_avg   = l_avg_q;
                            w_phase = best_phase_q + QSTEP;
                        end
                        trk_d        = 1'b0;
                        best_avg_d   = w_avg;
                        best_phase_d = w_phase;
                        phase_d      = w_phase;
                        if (w_avg < LOCK_THR) begin
                            locked_d = 1'b0;
                            fail_d   = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            state_d  = LOCK;
                        end
                    end
                end else
`endif
                begin
                    if (avg > best_avg_q) begin
                        best_avg_d   = avg;
                        best_phase_d = phase_q;
                    end
                    // Winner goes on the output now so the FINISH restart uses it.
                    if (step_q == STEP_LST) begin
                        phase_d = best_phase_d;
                        state_d = FINISH;
                    end else begin
                        state_d = STEP;
                    end
                end
            end
            STEP: begin
                phase_d = phase_q + PSTEP;
                step_d  = step_q + 17'd1;
                state_d = APPLY;
            end
            FINISH: begin
                busy_d = 1'b0;
                if (best_avg_q >= LOCK_THR) begin
                    locked_d = 1'b1;
                    state_d  = LOCK;
                end else begin
                    fail_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            LOCK: begin
`ifdef PHASE_TRACK_EN
                trk_d   = 1'b1;
                idx_d   = 2'd0;
                phase_d = best_phase_q - QSTEP;
                state_d = APPLY;
`endif
            end
            default: ;
        endcase

`ifdef PHASE_TRACK_EN
        if (start_i && (state_q == IDLE || state_q == LOCK || trk_q)) begin
            trk_d = 1'b0;
`else
        if (start_i && (state_q == IDLE || state_q == LOCK)) begin
`endif
            phase_d      = '0;
            best_avg_d   = '0;
            best_phase_d = '0;
            locked_d     = 1'b0;
            fail_d       = 1'b0;
            busy_d       = 1'b1;
            step_d       = '0;
            state_d      = APPLY;
        end
    end

    assign phase_o      = phase_q;
    assign demod_rst_o  = (state_q == APPLY) || (state_q == FINISH);
    assign done_o       = (state_q == FINISH);
    assign busy_o       = busy_q;
    assign locked_o     = locked_q;
    assign fail_o       = fail_q;
    assign best_phase_o = best_phase_q;
    assign best_avg_o   = best_avg_q;
endmodule

// File: tb/tb_phase_search_ctl.sv
// Directed bench for phase_search_ctl with a behavioural demodulator returning per-phase magnitudes.
module tb_phase_search_ctl;
    logic        clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, demod_rdy_i = 1'b0;
    logic [7:0]  demod_value_i = '0;
    logic [15:0] phase_o, best_phase_o;
    logic        demod_rst_o, busy_o, done_o, locked_o, fail_o;
    logic [7:0]  best_avg_o;

    int nvec = 0, nerr = 0, npulse = 0, cnt = 100;
    logic [15:0] pk1 = '0, pk2 = '0;
    logic [7:0]  v1 = '0, v2 = '0, vb = '0;

    phase_search_ctl dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .demod_value_i(demod_value_i), .demod_rdy_i(demod_rdy_i),
        .phase_o(phase_o), .demod_rst_o(demod_rst_o), .busy_o(busy_o), .done_o(done_o),
        .locked_o(locked_o), .fail_o(fail_o), .best_phase_o(best_phase_o), .best_avg_o(best_avg_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mag(input logic [15:0] p);
        if (p == pk1) return v1;
        if (p == pk2) return v2;
        return vb;
    endfunction

    // Demodulator model: first rdy 3 cycles after its restart, then every other cycle.
    always @(negedge clk) begin
        if (demod_rst_o) cnt = 0;
        else if (cnt < 1000) cnt = cnt + 1;
        demod_rdy_i   = (cnt >= 3) && (cnt % 2 == 1);
        demod_value_i = mag(phase_o);
    end

    always @(negedge clk) if (demod_rst_o && busy_o) npulse++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_model(input logic [15:0] a, input logic [7:0] av,
                             input logic [15:0] b, input logic [7:0] bv, input logic [7:0] base);
        pk1 = a; v1 = av; pk2 = b; v2 = bv; vb = base;
    endtask

    task automatic pulse_start();
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
    endtask

    // Runs until done, counting cycles where busy dropped early.
    task automatic wait_done(input string tag);
        int lows = 0;
        int n = 0;
        while (!done_o && n < 3000) begin
            if (!busy_o) lows++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, {31'd0, done_o}, 32'd1);
        chk({tag, "_busy_cont"}, lows, 0);
        @(negedge clk);
    endtask

    task automatic check_result(input string tag, input logic [15:0] bp, input logic [7:0] ba,
                                input logic lk);
        chk({tag, "_pulses"}, npulse, 17);
        chk({tag, "_done_1cyc"}, {31'd0, done_o}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_locked"}, {31'd0, locked_o}, {31'd0, lk});
        chk({tag, "_fail"}, {31'd0, fail_o}, {31'd0, ~lk});
        chk({tag, "_best_phase"}, {16'd0, best_phase_o}, {16'd0, bp});
        chk({tag, "_best_avg"}, {24'd0, best_avg_o}, {24'd0, ba});
        chk({tag, "_phase"}, {16'd0, phase_o}, {16'd0, bp});
    endtask

    task automatic wait_pulses(input string tag, input int target);
        int n = 0;
        while (npulse < target && n < 3000) begin @(negedge clk); n++; end
        chk({tag, "_reach_step"}, {31'd0, npulse >= target}, 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_phase", {16'd0, phase_o}, 32'd0);
        chk("rst_ctl", {26'd0, demod_rst_o, busy_o, done_o, locked_o, fail_o, 1'b0}, 32'd0);
        chk("rst_best", {8'd0, best_phase_o, best_avg_o}, 32'd0);
        rst_n = 1'b1;

        // Single peak
        set_model(16'h5000, 8'd40, 16'h5000, 8'd40, 8'd10);
        npulse = 0;
        pulse_start();
        chk("a_apply_phase0", {15'd0, phase_o, demod_rst_o}, 32'd1);
        wait_done("a");
        check_result("a", 16'h5000, 8'd40, 1'b1);

        // Tie keeps the earlier phase
        set_model(16'h3000, 8'd30, 16'hB000, 8'd30, 8'd10);
        npulse = 0;
        pulse_start();
        wait_done("b");
        check_result("b", 16'h3000, 8'd30, 1'b1);

        // Flat response below threshold
        set_model(16'h0000, 8'd8, 16'h0000, 8'd8, 8'd8);
        npulse = 0;
        pulse_start();
        wait_done("c");
        check_result("c", 16'h0000, 8'd8, 1'b0);
        begin
            int rs = 0;
            repeat (50) begin @(negedge clk); if (demod_rst_o) rs++; end
            chk("c_idle_quiet", rs, 0);
        end

        // start during a sweep is ignored
        set_model(16'h5000, 8'd40, 16'h5000, 8'd40, 8'd10);
        npulse = 0;
        pulse_start();
        wait_pulses("d", 5);
        start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        wait_done("d");
        check_result("d", 16'h5000, 8'd40, 1'b1);

        // Async reset inside MEASURE of step 7
        npulse = 0;
        pulse_start();
        wait_pulses("e", 8);
        repeat (7) @(negedge clk);
        chk("e_mid_phase", {16'd0, phase_o}, 32'h7000);
        #2 rst_n = 1'b0;
        #1;
        chk("e_rst_phase", {16'd0, phase_o}, 32'd0);
        chk("e_rst_ctl", {26'd0, demod_rst_o, busy_o, done_o, locked_o, fail_o, 1'b0}, 32'd0);
        chk("e_rst_best", {8'd0, best_phase_o, best_avg_o}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        npulse = 0;
        pulse_start();
        chk("e_restart_phase0", {15'd0, phase_o, demod_rst_o}, 32'd1);
        wait_done("e");
        check_result("e", 16'h5000, 8'd40, 1'b1);

`ifdef PHASE_TRACK_EN
        // Peak drifts by a quarter step; tracking follows it
        set_model(16'h5400, 8'd40, 16'h5400, 8'd40, 8'd10);
        begin
            int n = 0;
            while (best_phase_o != 16'h5400 && n < 200) begin @(negedge clk); n++; end
        end
        chk("f_track_phase", {16'd0, best_phase_o}, 32'h5400);
        chk("f_track_avg", {24'd0, best_avg_o}, 32'd40);
        chk("f_locked", {30'd0, locked_o, busy_o}, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/phase_search_ctl.md
Name: phase_search_ctl

Overview:
- Sequencer for the I/Q absolute-value demodulator: drives its 16-bit `phase` input and its active-high `rst_in`.
- Consumes the demodulator's `value`/`rdy` strobes.
- On `start`, performs a coarse sweep of the NCO phase offset. It averages 2^ACC_LOG2 correlator magnitudes per step and selects the phase with the largest average.
- Parks the demodulator on that phase and reports lock or failure to the surrounding DLL logic.

Parameters:
- PHASE_STEP, 16'h1000, phase increment per sweep step; power of two; step count NSTEPS = 65536/PHASE_STEP.
- SETTLE_CNT, 1, number of `demod_rdy` strobes discarded after each phase change (range 0..15).
- ACC_LOG2, 2, log2 of the number of samples averaged per step (range 0..4).
- LOCK_THR, 8'd16, minimum best average required to declare lock.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- demod_value  in  8  magnitude from the demodulator.
- demod_rdy  in  1  one-cycle strobe; `demod_value` valid in the same cycle.
- phase  out  16  phase offset to the demodulator.
- demod_rst  out  1  active-high restart pulse to the demodulator.
- busy  out  1  high from accepted `start` until `done`.
- done  out  1  one-cycle pulse at end of sweep.
- locked  out  1  sweep succeeded; held until next accepted `start` or reset.
- fail  out  1  sweep finished below LOCK_THR; held until next accepted `start` or reset.
- best_phase  out  16  winning phase.
- best_avg  out  8  winning average, i.e. accumulator >> ACC_LOG2.

Behaviour:
- Reset (async assert, sync release): IDLE state; all outputs 0; step, settle and sample counters and the accumulator cleared.
- Accepted `start` (IDLE or LOCK states only; ignored while `busy`): phase<=0, best_avg<=0, best_phase<=0, locked<=0, fail<=0, busy<=1, step<=0, enter APPLY.
- APPLY: demod_rst=1 for exactly one cycle with the new `phase` already on the output; settle counter<=SETTLE_CNT; enter SETTLE next cycle.
- SETTLE: each `demod_rdy` decrements the settle counter. At 0 (immediately if SETTLE_CNT=0), enter MEASURE with accumulator<=0 and sample counter<=0.
- MEASURE:
  - Each `demod_rdy` adds `demod_value` into an accumulator of width 8+ACC_LOG2; no overflow is possible.
  - After the 2^ACC_LOG2-th sample, enter COMPARE. That sample is included in the sum.
- COMPARE, one cycle: avg = acc[ACC_LOG2+7:ACC_LOG2].
  - If avg > best_avg (strictly), best_avg<=avg and best_phase<=phase. Ties keep the earlier, lower phase.
  - If step == NSTEPS-1, enter FINISH; else enter STEP.
- STEP: phase<=phase+PHASE_STEP (16-bit wrap, mod 65536); step<=step+1; enter APPLY.
- FINISH, one cycle: phase<=best_phase; demod_rst pulses for 1 cycle; done=1; busy<=0.
  - If best_avg >= LOCK_THR: locked<=1, enter LOCK.
  - Else: fail<=1, enter IDLE.
- LOCK: `phase` held at best_phase. Behaviour depends on PHASE_TRACK_EN (see Optional Feature). A new `start` restarts the sweep.
- `demod_rdy` strobes arriving in APPLY, COMPARE, STEP or FINISH are dropped, never counted.
- Timing of the demodulator: it produces `rdy` at least 3 cycles after `demod_rst`, so no strobe is lost at the SETTLE boundary.
- `start` and `demod_rdy` in the same cycle in LOCK: `start` wins and the sample is dropped.
- Reset asserted mid-sweep: immediate return to reset values, including phase=0 and demod_rst=0.

Optional Feature:
- Macro: PHASE_TRACK_EN.
- Defined: in LOCK, the block repeatedly measures, each for 2^ACC_LOG2 samples after SETTLE, three phases in order: early = best_phase-PHASE_STEP/4, late = best_phase+PHASE_STEP/4, then best_phase again. Each phase change uses the APPLY/SETTLE sequence.
  - If early_avg > max(late_avg, centre_avg): best_phase -= PHASE_STEP/4.
  - Else if late_avg > max(early_avg, centre_avg): best_phase += PHASE_STEP/4.
  - Otherwise best_phase holds.
  - best_avg <= the average at the winning phase.
  - If that average drops below LOCK_THR: locked<=0, fail<=1, enter IDLE.
  - `busy` stays 0 throughout tracking.
- Undefined: LOCK is static. No demod_rst pulses and no measurements occur until the next `start`.

Test Plan:
- Defaults; model returns avg 40 at phase 16'h5000 and 10 elsewhere; pulse start → 16 demod_rst pulses during sweep plus 1 in FINISH; done=1; locked=1; best_phase=16'h5000; best_avg=40; phase=16'h5000.
- Equal avg 30 at 16'h3000 and 16'hB000 → best_phase=16'h3000 (tie keeps first).
- All values 8 → done=1, fail=1, locked=0, best_avg=8, state IDLE.
- start pulsed again at step 4 → ignored; sweep completes with the same result; busy high continuously.
- rst_n low during MEASURE at step 7 → all outputs 0 asynchronously; a new start after release sweeps from phase 0.
- PHASE_TRACK_EN defined; peak model moved from 16'h5000 to 16'h5400 after lock → best_phase=16'h5400 within one tracking round; locked stays 1.
